riscv_mc_seq: RTL and testbench

RISCV_MC_SEQ -- requirements
Module: riscv_mc_seq

---
 rtl/riscv_mc_seq.sv | 195 +++++++++++++++++++
 tb/tb_riscv_mc_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mc_seq.sv
// Multi-cycle RISC-V control sequencer: fetch, decode, execute, load/store
// with bus timeout and illegal-opcode traps plus a retired-instruction count.
// Ports: clk, reset (async, high); opcode, mem_ready, stall in;
//   register/memory enables, mux selects, trap/trap_cause, instret, state out.
module riscv_mc_seq #(
  parameter int CNT_W  = 32,
  parameter int TO_CYC = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  input  logic             stall,
  output logic             pc_WE,
  output logic             addr_reg_WE,
  output logic             data_reg_WE,
  output logic             inst_reg_WE,
  output logic             grg_WE,
  output logic             mem_RE,
  output logic             mem_WE,
  output logic             sel_pc_grg,
  output logic             sel_mem_grg,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state
);

  localparam logic [3:0] IF_A  = 4'd0;
  localparam logic [3:0] IF_M  = 4'd1;
  localparam logic [3:0] IF_I  = 4'd2;
  localparam logic [3:0] DEC   = 4'd3;
  localparam logic [3:0] EX_WB = 4'd4;
  localparam logic [3:0] EX_PC = 4'd5;
  localparam logic [3:0] LS_A  = 4'd6;
  localparam logic [3:0] LS_M  = 4'd7;
  localparam logic [3:0] LD_WB = 4'd8;
  localparam logic [3:0] TRAP  = 4'd9;

  localparam logic [7:0] TO_LIM = 8'(TO_CYC);

  logic [3:0]       state_q;
  logic [3:0]       state_d;
  logic [7:0]       wait_q;
  logic             is_store_q;
  logic             trap_q;
  logic [1:0]       cause_q;
  logic [CNT_W-1:0] instret_q;

  logic       retire;
  logic [1:0] fault;
  logic       timeout;
  logic       dec_store;
  logic       dec_ls;
  logic       dec_ex;
  logic       dec_br;

  always_comb begin
    dec_store = opcode == 7'b0100011;
    dec_ls    = dec_store || opcode == 7'b0000011;
    dec_br    = opcode == 7'b1100011;
    dec_ex    = opcode == 7'b0110011 || opcode == 7'b0010011 ||
                opcode == 7'b0110111 || opcode == 7'b0010111 ||
                opcode == 7'b1101111 || opcode == 7'b1100111;
  end

  // A ready response in the limit cycle still completes the access.
  assign timeout = !mem_ready && wait_q == TO_LIM;

  always_comb begin
    state_d     = state_q;
    pc_WE       = 1'b0;
    addr_reg_WE = 1'b0;
    data_reg_WE = 1'b0;
    inst_reg_WE = 1'b0;
    grg_WE      = 1'b0;
    mem_RE      = 1'b0;
    mem_WE      = 1'b0;
    sel_pc_grg  = 1'b0;
    sel_mem_grg = 1'b0;
    retire      = 1'b0;
    fault       = 2'b00;
    case (state_q)
      IF_A: begin
        if (!stall) begin
          addr_reg_WE = 1'b1;
          state_d     = IF_M;
        end
      end
      IF_M: begin
        mem_RE = 1'b1;
        if (mem_ready) begin
          data_reg_WE = 1'b1;
          state_d     = IF_I;
        end else if (timeout) begin
          state_d = TRAP;
          fault   = 2'b10;
        end
      end
      IF_I: begin
        inst_reg_WE = 1'b1;
        state_d     = DEC;
      end
      DEC: begin
        unique case (1'b1)
          dec_ls:  state_d = LS_A;
          dec_ex:  state_d = EX_WB;
          dec_br:  state_d = EX_PC;
          default: begin
            state_d = TRAP;
            fault   = 2'b01;
          end
        endcase
      end
      EX_WB: begin
        grg_WE  = 1'b1;
        pc_WE   = 1'b1;
        retire  = 1'b1;
        state_d = IF_A;
      end
      EX_PC: begin
        pc_WE   = 1'b1;
        retire  = 1'b1;
        state_d = IF_A;
      end
      LS_A: begin
        addr_reg_WE = 1'b1;
        sel_pc_grg  = 1'b1;
        data_reg_WE = is_store_q;
        sel_mem_grg = is_store_q;
        state_d     = LS_M;
      end
      LS_M: begin
        mem_WE = is_store_q;
        mem_RE = !is_store_q;
        if (mem_ready) begin
          if (is_store_q) begin
            pc_WE   = 1'b1;
            retire  = 1'b1;
            state_d = IF_A;
          end else begin
            data_reg_WE = 1'b1;
            state_d     = LD_WB;
          end
        end else if (timeout) begin
          state_d = TRAP;
          fault   = 2'b10;
        end
      end
      LD_WB: begin
        grg_WE  = 1'b1;
        pc_WE   = 1'b1;
        retire  = 1'b1;
        state_d = IF_A;
      end
      TRAP: state_d = TRAP;
      default: begin
        state_d = TRAP;
        fault   = 2'b01;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IF_A;
      wait_q     <= 8'd0;
      is_store_q <= 1'b0;
      trap_q     <= 1'b0;
      cause_q    <= 2'b00;
      instret_q  <= '0;
    end else begin
      state_q <= state_d;
      // Outside the memory states the counter sits at zero, so every
      // entry into IF_M/LS_M starts a fresh count.
      if (state_q == IF_M || state_q == LS_M) begin
        if (!mem_ready && !timeout) wait_q <= wait_q + 8'd1;
      end else begin
        wait_q <= 8'd0;
      end
      if (state_q == DEC) is_store_q <= dec_store;
      if (fault != 2'b00) begin
        trap_q  <= 1'b1;
        cause_q <= fault;
      end
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign instret    = instret_q;
  assign state      = state_q;

endmodule

// File: tb/tb_riscv_mc_seq.sv
// Self-checking bench for riscv_mc_seq (CNT_W=4, TO_CYC=4).
// Table of instructions with scoreboard plus hand-written corner sequences.
module tb_riscv_mc_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       mem_ready = 1'b0;
  logic       stall = 1'b1;
  logic       pc_WE, addr_reg_WE, data_reg_WE, inst_reg_WE, grg_WE;
  logic       mem_RE, mem_WE, sel_pc_grg, sel_mem_grg, trap;
  logic [1:0] trap_cause;
  logic [3:0] instret;
  logic [3:0] state;

  riscv_mc_seq #(.CNT_W(4), .TO_CYC(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .mem_ready(mem_ready), .stall(stall),
    .pc_WE(pc_WE), .addr_reg_WE(addr_reg_WE),
    .data_reg_WE(data_reg_WE), .inst_reg_WE(inst_reg_WE),
    .grg_WE(grg_WE), .mem_RE(mem_RE), .mem_WE(mem_WE),
    .sel_pc_grg(sel_pc_grg), .sel_mem_grg(sel_mem_grg),
    .trap(trap), .trap_cause(trap_cause),
    .instret(instret), .state(state)
  );

  always #5 clk = ~clk;

  logic [8:0] en_bus;
  assign en_bus = {pc_WE, addr_reg_WE, data_reg_WE, inst_reg_WE,
                   grg_WE, mem_RE, mem_WE, sel_pc_grg, sel_mem_grg};

  int n_cmp = 0;
  int n_bad = 0;
  int exp_ret = 0;

  typedef struct {
    logic [6:0] op;
    int         fw;
    int         lw;
    int         cyc;
    int         re;
    int         we;
    bit         grg;
    bit         trp;
    logic [1:0] cause;
    int         ret;
  } vec_t;

  vec_t tbl [17];
  vec_t sb [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic reset_dut();
    stall = 1'b1;
    mem_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    exp_ret = 0;
  endtask

  // Runs one instruction from IF_A until IF_A or TRAP is reached again.
  task automatic run_instr(input logic [6:0] op, input int fw, input int lw,
                           output int cyc, output int re, output int we,
                           output bit grg, output bit clash);
    int w;
    cyc = 0; re = 0; we = 0; grg = 0; clash = 0; w = 0;
    do begin
      @(negedge clk);
      opcode = op;
      stall = 1'b0;
      case (state)
        4'd1:    mem_ready = (w >= fw);
        4'd7:    mem_ready = (w >= lw);
        default: mem_ready = 1'b0;
      endcase
      #1;
      if (mem_RE) re++;
      if (mem_WE) we++;
      if (grg_WE) grg = 1;
      if (mem_RE && mem_WE) clash = 1;
      if (state == 4'd1 || state == 4'd7) w = mem_ready ? 0 : w + 1;
      cyc++;
      @(posedge clk);
      #1;
    end while (state != 4'd0 && state != 4'd9 && cyc < 64);
    mem_ready = 1'b0;
    stall = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t e;
    int cyc, re, we;
    bit grg, clash;
    logic [3:0] seq [6];
    int k;

    tbl[0]  = '{7'b0110011, 0, 0, 5, 1, 0, 1, 0, 2'b00, 1};
    tbl[1]  = '{7'b0010011, 1, 0, 6, 2, 0, 1, 0, 2'b00, 1};
    tbl[2]  = '{7'b0110111, 2, 0, 7, 3, 0, 1, 0, 2'b00, 1};
    tbl[3]  = '{7'b0010111, 0, 0, 5, 1, 0, 1, 0, 2'b00, 1};
    tbl[4]  = '{7'b1101111, 0, 0, 5, 1, 0, 1, 0, 2'b00, 1};
    tbl[5]  = '{7'b1100111, 0, 0, 5, 1, 0, 1, 0, 2'b00, 1};
    tbl[6]  = '{7'b1100011, 0, 0, 5, 1, 0, 0, 0, 2'b00, 1};
    tbl[7]  = '{7'b0100011, 0, 0, 6, 1, 1, 0, 0, 2'b00, 1};
    tbl[8]  = '{7'b0100011, 0, 2, 8, 1, 3, 0, 0, 2'b00, 1};
    tbl[9]  = '{7'b0000011, 0, 0, 7, 2, 0, 1, 0, 2'b00, 1};
    tbl[10] = '{7'b0000011, 0, 3, 10, 5, 0, 1, 0, 2'b00, 1};
    tbl[11] = '{7'b0000011, 4, 4, 15, 10, 0, 1, 0, 2'b00, 1};
    tbl[12] = '{7'b1111111, 0, 0, 4, 1, 0, 0, 1, 2'b01, 0};
    tbl[13] = '{7'b0001111, 0, 0, 4, 1, 0, 0, 1, 2'b01, 0};
    tbl[14] = '{7'b0110011, 99, 0, 6, 5, 0, 0, 1, 2'b10, 0};
    tbl[15] = '{7'b0000011, 0, 99, 10, 6, 0, 0, 1, 2'b10, 0};
    tbl[16] = '{7'b0100011, 0, 99, 10, 1, 5, 0, 1, 2'b10, 0};

    // Reset state
    reset_dut();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_en", 32'(en_bus), 32'd0);
    chk("rst_trap", 32'({trap, trap_cause}), 32'd0);
    chk("rst_instret", 32'(instret), 32'd0);

    // ALU trajectory 0,1,2,3,4,0
    seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    opcode = 7'b0110011;
    mem_ready = 1'b1;
    stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("alu_state", 32'(state), 32'(seq[i]));
      if (i == 4) chk("alu_wb_en", 32'({grg_WE, pc_WE}), 32'd3);
      if (i == 5) stall = 1'b1;
      if (i < 5) begin
        @(posedge clk);
        #1;
      end
    end
    mem_ready = 1'b0;
    chk("alu_instret", 32'(instret), 32'd1);

    // Stall holds IF_A with no enables
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("stall_state", 32'(state), 32'd0);
      chk("stall_en", 32'(en_bus), 32'd0);
    end

    // Table-driven instructions through the scoreboard
    reset_dut();
    for (int i = 0; i < 17; i++) begin
      sb.push_back(tbl[i]);
      run_instr(tbl[i].op, tbl[i].fw, tbl[i].lw, cyc, re, we, grg, clash);
      e = sb.pop_front();
      chk($sformatf("v%0d_cyc", i), 32'(cyc), 32'(e.cyc));
      chk($sformatf("v%0d_re", i), 32'(re), 32'(e.re));
      chk($sformatf("v%0d_we", i), 32'(we), 32'(e.we));
      chk($sformatf("v%0d_grg", i), 32'(grg), 32'(e.grg));
      chk($sformatf("v%0d_clash", i), 32'(clash), 32'd0);
      chk($sformatf("v%0d_trap", i), 32'(trap), 32'(e.trp));
      chk($sformatf("v%0d_cause", i), 32'(trap_cause), 32'(e.cause));
      exp_ret = (exp_ret + e.ret) % 16;
      chk($sformatf("v%0d_instret", i), 32'(instret), 32'(exp_ret));
      if (e.trp) begin
        mem_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
          @(posedge clk);
          #1;
          chk($sformatf("v%0d_hold_st", i), 32'(state), 32'd9);
          chk($sformatf("v%0d_hold_en", i), 32'(en_bus), 32'd0);
          chk($sformatf("v%0d_hold_tc", i), 32'({trap, trap_cause}),
              32'({1'b1, e.cause}));
        end
        reset_dut();
        chk($sformatf("v%0d_clr", i), 32'({trap, trap_cause, state}), 32'd0);
      end
    end

    // Store: LS_A enables and held mem_WE
    reset_dut();
    opcode = 7'b0100011;
    mem_ready = 1'b1;
    stall = 1'b0;
    k = 0;
    while (state != 4'd6 && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("st_lsa_state", 32'(state), 32'd6);
    chk("st_lsa_en", 32'(en_bus), 32'b011_0000_11);
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("st_lsm_req", 32'({state, mem_RE, mem_WE, grg_WE}), 32'b0111_010);
    end
    mem_ready = 1'b1;
    stall = 1'b1;
    #1;
    chk("st_done_pc", 32'(pc_WE), 32'd1);
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    chk("st_back", 32'({state, instret}), 32'({4'd0, 4'd1}));

    // instret wraps after 16 retires
    reset_dut();
    for (int i = 0; i < 15; i++)
      run_instr(7'b0110011, 0, 0, cyc, re, we, grg, clash);
    chk("wrap_15", 32'(instret), 32'd15);
    run_instr(7'b0110011, 0, 0, cyc, re, we, grg, clash);
    chk("wrap_0", 32'(instret), 32'd0);
    run_instr(7'b0010011, 0, 0, cyc, re, we, grg, clash);
    chk("wrap_1", 32'(instret), 32'd1);

    // Reset during a pending fetch read
    mem_ready = 1'b0;
    stall = 1'b0;
    @(posedge clk);
    #1;
    chk("rim_req", 32'({state, mem_RE}), 32'({4'd1, 1'b1}));
    #2;
    reset = 1'b1;
    #1;
    chk("rim_drop", 32'({state, mem_RE, instret}), 32'd0);
    stall = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rim_idle", 32'(state), 32'd0);
    stall = 1'b0;
    @(posedge clk);
    #1;
    chk("rim_refetch", 32'({state, mem_RE}), 32'({4'd1, 1'b1}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
